aes_iter_core: RTL and testbench

AES_ITER_CORE -- requirements
Module: aes_iter_core

---
 rtl/aes_iter_core.sv | 160 ++++++++++++++++
 tb/tb_aes_iter_core.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_iter_core.sv
// Iterative AES-128/192/256 core, one round per clock; result Nr edges after acceptance.
// Single block in flight: in_ready only in IDLE, result held in DONE until out_ready.
module aes_iter_core #(
    parameter  int Nk = 4,
    localparam int Nr = Nk + 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     mode,
    input  logic [0:127]             data_in,
    input  logic [0:128*(Nr+1)-1]    keys,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [0:127]             data_out,
    output logic                     busy
);

    generate
        if (!(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_bad_nk
            $fatal(1, "aes_iter_core: Nk must be 4, 6 or 8");
        end
    endgenerate

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    localparam logic [0:2047] ISBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] c);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (c[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [0:127] sub_bytes(input logic [0:127] s, input logic inv);
        logic [0:127] r;
        for (int i = 0; i < 16; i++)
            r[8*i +: 8] = inv ? ISBOX[8*int'(s[8*i +: 8]) +: 8] : SBOX[8*int'(s[8*i +: 8]) +: 8];
        return r;
    endfunction

    // Byte i sits in column i/4, row i%4; row r rotates left by r (right when inverting).
    function automatic logic [0:127] shift_rows(input logic [0:127] s, input logic inv);
        logic [0:127] r;
        int sh;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) begin
                sh = inv ? (4 - w) % 4 : w;
                r[8*(w + 4*c) +: 8] = s[8*(w + 4*((c + sh) % 4)) +: 8];
            end
        return r;
    endfunction

    function automatic logic [0:127] mix_columns(input logic [0:127] s, input logic inv);
        logic [0:127] r;
        logic [15:0]  coefs;
        logic [7:0]   acc;
        coefs = inv ? 16'hebd9 : 16'h2311;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) begin
                acc = '0;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(s[8*(4*c + j) +: 8], coefs[15 - 4*((j - w + 4) % 4) -: 4]);
                r[8*(4*c + w) +: 8] = acc;
            end
        return r;
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state, state_nxt;
    logic [3:0]   rnd, kr;
    logic         mode_r, last;
    logic [0:127] st, init_key, enc_key, dec_key;
    logic [0:127] enc_mid, enc_next, dec_mid, dec_next, round_out;

    assign last = (rnd == 4'(Nr));
    // rnd runs one past Nr while in DONE; clamp so the key selects stay in range.
    assign kr       = (rnd > 4'(Nr)) ? 4'(Nr) : rnd;
    assign enc_key  = keys[128*int'(kr) +: 128];
    assign dec_key  = keys[128*(Nr - int'(kr)) +: 128];
    assign init_key = mode ? keys[128*Nr +: 128] : keys[0 +: 128];

    assign enc_mid   = shift_rows(sub_bytes(st, 1'b0), 1'b0);
    assign enc_next  = (last ? enc_mid : mix_columns(enc_mid, 1'b0)) ^ enc_key;
    assign dec_mid   = sub_bytes(shift_rows(st, 1'b1), 1'b1) ^ dec_key;
    assign dec_next  = last ? dec_mid : mix_columns(dec_mid, 1'b1);
    assign round_out = mode_r ? dec_next : enc_next;

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rnd      <= '0;
            mode_r   <= 1'b0;
            st       <= '0;
            data_out <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    mode_r <= mode;
                    st     <= data_in ^ init_key;
                    rnd    <= 4'd1;
                end
                RUN: begin
                    st  <= round_out;
                    rnd <= rnd + 4'd1;
                    if (last) data_out <= round_out;
                end
                DONE: if (out_ready) rnd <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_iter_core.sv
// Scoreboarded bench for aes_iter_core at Nk = 4, 6 and 8 using the FIPS-197 appendix C vectors.
module tb_aes_iter_core;

    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT8 = 128'h8ea2b7ca516745bfeafc49904b496089;

    typedef struct {
        logic [127:0] dat;
        bit           chk;
        int           acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int n_done = 0;

    task automatic chk(input int nk, input string name, input logic [127:0] act, input logic [127:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL nk=%0d %s: got %h, expected %h", nk, name, act, want);
        end
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8), then the affine map.
    function automatic logic [7:0] sbm(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = gm(r, x);
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbm(t[31:24]), sbm(t[23:16]), sbm(t[15:8]), sbm(t[7:0])};
    endfunction

    // Key schedule for key bytes 00,01,02,... of length 4*nk bytes.
    function automatic logic [0:1919] expand(input int nk);
        logic [31:0]   w [60];
        logic [0:1919] k;
        logic [31:0]   t;
        logic [7:0]    rc;
        k  = '0;
        rc = 8'h01;
        for (int i = 0; i < 60; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
        for (int i = nk; i < 4*(nk+7); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < 4*(nk+7); i++) k[32*i +: 32] = w[i];
        return k;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : inst
        localparam int NK = 4 + 2*g;
        localparam int NR = NK + 6;
        localparam logic [127:0] CT = (g == 0) ? CT4 : (g == 1) ? CT6 : CT8;

        logic reset     = 1'b1;
        logic in_valid  = 1'b0;
        logic mode      = 1'b0;
        logic out_ready = 1'b1;
        logic in_ready, out_valid, busy;
        logic [0:127]          data_in = '0;
        logic [0:127]          data_out;
        logic [0:1919]         kfull = '0;
        logic [0:128*(NR+1)-1] keys;

        exp_t         q[$];
        exp_t         e;
        logic [127:0] last_out = '0;
        logic [127:0] p;
        int           first_cyc = 0;
        int           prev_first = -1;
        bit           seen = 0;
        bit           tp_on = 0;

        assign keys = kfull[0 +: 128*(NR+1)];

        aes_iter_core #(.Nk(NK)) dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .mode      (mode),
            .data_in   (data_in),
            .keys      (keys),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .data_out  (data_out),
            .busy      (busy)
        );

        always @(negedge clk) begin
            if (out_valid) begin
                if (!seen) begin
                    first_cyc = cyc;
                    seen      = 1;
                end
                if (out_ready) begin
                    seen     = 0;
                    last_out = data_out;
                    chk(NK, "result was expected", 128'(q.size() != 0), 1);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        if (e.chk) chk(NK, "data_out", data_out, e.dat);
                        chk(NK, "latency", first_cyc - e.acc, NR);
                        if (tp_on && prev_first >= 0)
                            chk(NK, "throughput gap", first_cyc - prev_first, NR + 2);
                        prev_first = first_cyc;
                    end
                end
            end
        end

        task automatic send(input logic [127:0] d, input bit m, input bit fb,
                            input logic [127:0] want, input bit c, input bit hold);
            int n = 0;
            while (!in_ready && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            chk(NK, "in_ready before send", in_ready, 1);
            in_valid = 1'b1;
            mode     = m;
            data_in  = fb ? last_out : d;
            @(posedge clk); #1;
            q.push_back('{dat: want, chk: c, acc: cyc});
            if (!hold) in_valid = 1'b0;
        endtask

        task automatic drain();
            int n = 0;
            while (q.size() != 0 && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            chk(NK, "scoreboard drained", q.size(), 0);
            @(posedge clk); #1;
        endtask

        initial begin
            int n;
            kfull = expand(NK);
            #3;
            chk(NK, "reset in_ready", in_ready, 1);
            chk(NK, "reset out_valid", out_valid, 0);
            chk(NK, "reset busy", busy, 0);
            chk(NK, "reset data_out", data_out, 0);
            @(posedge clk); #1;
            reset = 1'b0;
            @(posedge clk); #1;

            send(PT, 1'b0, 1'b0, CT, 1'b1, 1'b0);
            drain();
            send(CT, 1'b1, 1'b0, PT, 1'b1, 1'b0);
            drain();

            // Result held under backpressure while a second block is offered.
            out_ready = 1'b0;
            send(PT, 1'b0, 1'b0, CT, 1'b1, 1'b0);
            n = 0;
            while (!out_valid && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            chk(NK, "bp result arrived", out_valid, 1);
            for (int i = 0; i < 5; i++) begin
                in_valid = 1'b1;
                mode     = 1'b1;
                data_in  = ~PT;
                @(posedge clk); #1;
                chk(NK, "bp out_valid", out_valid, 1);
                chk(NK, "bp data_out", data_out, CT);
                chk(NK, "bp in_ready", in_ready, 0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(posedge clk); #1;
            chk(NK, "idle after handshake", in_ready, 1);
            send(CT, 1'b1, 1'b0, PT, 1'b1, 1'b0);
            drain();

            // Live mode and data pins are irrelevant once a block is running.
            send(PT, 1'b0, 1'b0, CT, 1'b1, 1'b0);
            for (int i = 0; i < 4; i++) begin
                mode    = ~mode;
                data_in = {$urandom, $urandom, $urandom, $urandom};
                @(posedge clk); #1;
            end
            mode = 1'b0;
            drain();

            // Abandon a block at round 5.
            send(PT, 1'b0, 1'b0, CT, 1'b1, 1'b0);
            void'(q.pop_back());
            repeat (4) begin
                @(posedge clk); #1;
            end
            #2;
            reset = 1'b1;
            #1;
            chk(NK, "mid-run reset out_valid", out_valid, 0);
            chk(NK, "mid-run reset data_out", data_out, 0);
            chk(NK, "mid-run reset in_ready", in_ready, 1);
            chk(NK, "mid-run reset busy", busy, 0);
            @(posedge clk); #1;
            reset = 1'b0;
            send(PT, 1'b0, 1'b0, CT, 1'b1, 1'b0);
            drain();

            // Back-to-back encrypt/decrypt round trips with in_valid held high.
            tp_on      = 1;
            prev_first = -1;
            for (int k = 0; k < 10; k++) begin
                p = {$urandom, $urandom, $urandom, $urandom};
                send(p, 1'b0, 1'b0, '0, 1'b0, 1'b1);
                send('0, 1'b1, 1'b1, p, 1'b1, k != 9);
            end
            drain();
            tp_on = 0;
            n_done++;
        end
    end

    initial begin
        int t = 0;
        while (n_done < 3 && t < 20000) begin
            @(posedge clk);
            t++;
        end
        chk(0, "instances finished", n_done, 3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
